// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Watches the (asynchronous) PLL LOCK output from the 25 MHz reference domain,
// debounces it, and generates the system reset for all PLL-clocked logic.
// Because it runs on the PLL reference clock, it keeps working while the PLL
// is unlocked.
//
// Optional feature macro: PLL_RELOCK_EN
//   defined   : a WAIT timeout enters RELOCK, which pulses pll_rst for
//               RST_PULSE_CYCLES and then retries from WAIT, forever.
//   undefined : pll_rst is tied 0. On timeout the FSM stays in WAIT with the
//               counter held, and timeout stays set.
//
// Ports
//   clk        in   1      25 MHz reference clock
//   rst_n      in   1      asynchronous, active-low reset
//   locked     in   1      PLL LOCK, asynchronous to clk
//   sys_rst_n  out  1      system reset, low = reset (high only in RUN)
//   ready      out  1      high while state==RUN
//   timeout    out  1      sticky: no lock within TIMEOUT_CYCLES
//   loss_cnt   out  CNT_W  lock losses seen in RUN, saturating
//   pll_rst    out  1      drives EHXPLLL RST
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES      = 2,
    parameter int STABLE_CYCLES    = 1024,
    parameter int HOLD_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int RST_PULSE_CYCLES = 8,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             timeout,
    output logic [CNT_W-1:0] loss_cnt,
    output logic             pll_rst
);

    // One counter is shared by every state, so it must cover the largest count.
    localparam int MAX_A = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_B = (TIMEOUT_CYCLES > RST_PULSE_CYCLES) ? TIMEOUT_CYCLES : RST_PULSE_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] STABLE_TC  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_TC    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_STABLE,
        S_HOLD,
        S_RUN,
        S_RELOCK
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;

    assign lock_s = sync[SYNC_STAGES-1];

`ifdef PLL_RELOCK_EN
    localparam logic [CW-1:0] PULSE_TC = CW'(RST_PULSE_CYCLES - 1);
`else
    assign pll_rst = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_WAIT;
            cnt       <= '0;
            sync      <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            timeout   <= 1'b0;
            loss_cnt  <= '0;
`ifdef PLL_RELOCK_EN
            pll_rst   <= 1'b0;
`endif
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};

            case (state)
                S_WAIT: begin
                    // Lock wins over a simultaneous terminal count.
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_TC) begin
                        timeout <= 1'b1;
`ifdef PLL_RELOCK_EN
                        state   <= S_RELOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
`endif
                        // Without relock the counter simply parks here.
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_TC) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_HOLD: begin
                    if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == HOLD_TC) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                        timeout   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        if (loss_cnt != {CNT_W{1'b1}})
                            loss_cnt <= loss_cnt + CNT_W'(1);
                    end
                end

`ifdef PLL_RELOCK_EN
                S_RELOCK: begin
                    // Lock state is ignored until the RST pulse has finished.
                    if (cnt == PULSE_TC) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                default: begin
                    state     <= S_WAIT;
                    cnt       <= '0;
                    sys_rst_n <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             locked;
    logic             sys_rst_n;
    logic             ready;
    logic             timeout;
    logic [CNT_W-1:0] loss_cnt;
    logic             pll_rst;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES     (2),
        .STABLE_CYCLES   (16),
        .HOLD_CYCLES     (4),
        .TIMEOUT_CYCLES  (64),
        .RST_PULSE_CYCLES(3),
        .CNT_W           (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .locked   (locked),
        .sys_rst_n(sys_rst_n),
        .ready    (ready),
        .timeout  (timeout),
        .loss_cnt (loss_cnt),
        .pll_rst  (pll_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rst: pulse rst_n before applying; lk: locked level; n: clk edges to run
    typedef struct {
        bit    rst;
        bit    lk;
        int    n;
        bit    srn;
        bit    rdy;
        bit    to;
        int    loss;
        bit    prst;
        string name;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit rst, input bit lk, input int n, input bit srn,
                       input bit rdy, input bit to, input int loss, input bit prst,
                       input string name);
        vec_t v;
        v.rst = rst; v.lk = lk; v.n = n; v.srn = srn; v.rdy = rdy;
        v.to = to; v.loss = loss; v.prst = prst; v.name = name;
        vt.push_back(v);
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input bit srn, input bit rdy,
                             input bit to, input int loss, input bit prst);
        checks++;
        if (sys_rst_n !== srn || ready !== rdy || timeout !== to ||
            loss_cnt !== CNT_W'(loss) || pll_rst !== prst) begin
            errors++;
            $display("FAIL %s: got srn=%b rdy=%b to=%b loss=%0d prst=%b, want srn=%b rdy=%b to=%b loss=%0d prst=%b",
                     name, sys_rst_n, ready, timeout, loss_cnt, pll_rst,
                     srn, rdy, to, loss, prst);
        end
    endtask

    task automatic do_reset(input bit lk);
        locked = lk;
        rst_n  = 1'b0;
        #2;
        check_all("reset_values", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        #3;

        // --- basic qualification, loss, and restart ---
        add(1, 0,  5, 0, 0, 0, 0, 0, "idle_unlocked");
        add(0, 1, 22, 0, 0, 0, 0, 0, "lock_edge22_still_reset");
        add(0, 1,  1, 1, 1, 0, 0, 0, "lock_edge23_release");
        add(0, 1, 10, 1, 1, 0, 0, 0, "run_stays_high");
        add(0, 0,  2, 1, 1, 0, 0, 0, "drop_edge2_still_run");
        add(0, 0,  1, 0, 0, 0, 1, 0, "drop_edge3_reset_loss1");
        add(0, 0,  2, 0, 0, 0, 1, 0, "drop_held");
        add(0, 1, 22, 0, 0, 0, 1, 0, "relock_edge22");
        add(0, 1,  1, 1, 1, 0, 1, 0, "relock_edge23_release");
        add(0, 0,  3, 0, 0, 0, 2, 0, "second_loss");
        add(0, 1, 10, 0, 0, 0, 2, 0, "short_lock_10");
        add(0, 0,  5, 0, 0, 0, 2, 0, "drop_during_stable_no_loss");
        add(0, 1, 22, 0, 0, 0, 2, 0, "requal_edge22");
        add(0, 1,  1, 1, 1, 0, 2, 0, "requal_edge23_release");
        // --- drop during HOLD is not a loss and restarts qualification ---
        add(0, 0,  3, 0, 0, 0, 3, 0, "third_loss");
        add(0, 1, 20, 0, 0, 0, 3, 0, "into_hold");
        add(0, 0,  4, 0, 0, 0, 3, 0, "drop_during_hold_no_loss");
        add(0, 1, 22, 0, 0, 0, 3, 0, "hold_requal_edge22");
        add(0, 1,  1, 1, 1, 0, 3, 0, "hold_requal_edge23");
        // --- lock timeout ---
        add(1, 0, 63, 0, 0, 0, 0, 0, "timeout_edge63_clear");
`ifdef PLL_RELOCK_EN
        add(0, 0,  1, 0, 0, 1, 0, 1, "timeout_edge64_pulse");
        add(0, 0,  2, 0, 0, 1, 0, 1, "pulse_held_3");
        add(0, 0,  1, 0, 0, 1, 0, 0, "pulse_end");
        add(0, 0, 63, 0, 0, 1, 0, 0, "retry_wait");
        add(0, 0,  1, 0, 0, 1, 0, 1, "second_pulse");
        add(0, 0,  3, 0, 0, 1, 0, 0, "second_pulse_end");
`else
        add(0, 0,  1, 0, 0, 1, 0, 0, "timeout_edge64_set");
        add(0, 0, 80, 0, 0, 1, 0, 0, "timeout_sticky_no_pllrst");
`endif
        add(0, 1, 22, 0, 0, 1, 0, 0, "late_lock_edge22");
        add(0, 1,  1, 1, 1, 0, 0, 0, "late_lock_run_clears_timeout");

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset(vt[i].lk);
            locked = vt[i].lk;
            step(vt[i].n);
            check_all(vt[i].name, vt[i].srn, vt[i].rdy, vt[i].to,
                      vt[i].loss, vt[i].prst);
        end

        // --- loss counter saturation over 260 losses ---
        do_reset(1'b1);
        step(23);
        check_all("sat_initial_run", 1'b1, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            int exp_loss;
            exp_loss = (i + 1 > 255) ? 255 : i + 1;
            locked = 1'b0;
            step(3);
            check_all("sat_drop", 1'b0, 1'b0, 1'b0, exp_loss, 1'b0);
            step(2);
            locked = 1'b1;
            step(23);
            check_all("sat_rerelease", 1'b1, 1'b1, 1'b0, exp_loss, 1'b0);
        end

        // --- asynchronous reset while in RUN ---
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset_in_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b1;
        step(22);
        check_all("after_async_edge22", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1);
        check_all("after_async_edge23", 1'b1, 1'b1, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
